// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: frames one 48-bit command, polls for R1,
// and drives chip select around the byte-level SPI controller.
module sd_cmd_sequencer #(
  parameter int RESP_TIMEOUT = 8,
  parameter int PRE_FILL     = 1,
  parameter int POST_FILL    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp_r1,
  output logic        timeout,
  output logic        cs_n,
  output logic        spi_execute,
  output logic [7:0]  spi_out_word,
  input  logic [7:0]  spi_in_word,
  input  logic        spi_finished,
  input  logic        spi_busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SEND = 3'd2,
    ST_POLL = 3'd3,
    ST_POST = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [3:0] PRE_LAST   = 4'(PRE_FILL - 1);
  localparam logic [3:0] POST_LAST  = 4'(POST_FILL - 1);
  localparam logic [7:0] POLL_LIMIT = 8'(RESP_TIMEOUT);

  state_t      state_r, state_n;
  logic [2:0]  byte_cnt_r, byte_cnt_n;
  logic [3:0]  fill_cnt_r, fill_cnt_n;
  logic [7:0]  poll_cnt_r, poll_cnt_n;
  logic        pending_r, pending_n;
  logic [5:0]  index_r, index_n;
  logic [31:0] arg_r, arg_n;
  logic [6:0]  crc_r, crc_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;
  logic [7:0]  resp_r, resp_n;
  logic        timeout_r, timeout_n;
  logic        cs_n_r, cs_n_n;
  logic        exec_r, exec_n;
  logic [7:0]  out_word_r, out_word_n;

  logic        byte_done_s;
  logic        need_issue_s;
  logic        enter_post_s;
  logic        enter_done_s;
  logic [7:0]  frame_byte_s;
  logic [7:0]  tx_byte_s;

  // Command frame byte selected by the SEND byte counter.
  always_comb begin
    frame_byte_s = 8'hFF;
    case (byte_cnt_r)
      3'd0:    frame_byte_s = {2'b01, index_r};
      3'd1:    frame_byte_s = arg_r[31:24];
      3'd2:    frame_byte_s = arg_r[23:16];
      3'd3:    frame_byte_s = arg_r[15:8];
      3'd4:    frame_byte_s = arg_r[7:0];
      3'd5:    frame_byte_s = {crc_r, 1'b1};
      default: frame_byte_s = 8'hFF;
    endcase
  end

  // Next-state, byte issue handshake and output register values.
  always_comb begin
    state_n      = state_r;
    byte_cnt_n   = byte_cnt_r;
    fill_cnt_n   = fill_cnt_r;
    poll_cnt_n   = poll_cnt_r;
    pending_n    = pending_r;
    index_n      = index_r;
    arg_n        = arg_r;
    crc_n        = crc_r;
    busy_n       = busy_r;
    done_n       = 1'b0;
    resp_n       = resp_r;
    timeout_n    = timeout_r;
    cs_n_n       = cs_n_r;
    exec_n       = 1'b0;
    out_word_n   = out_word_r;
    enter_post_s = 1'b0;
    enter_done_s = 1'b0;

    // A finish pulse only counts when one of our own issues is outstanding.
    byte_done_s  = pending_r && spi_finished;
    need_issue_s = (state_r == ST_PRE) || (state_r == ST_SEND) ||
                   (state_r == ST_POLL) || (state_r == ST_POST);
    tx_byte_s    = (state_r == ST_SEND) ? frame_byte_s : 8'hFF;

    if (need_issue_s && !pending_r && !spi_busy) begin
      exec_n     = 1'b1;
      pending_n  = 1'b1;
      out_word_n = tx_byte_s;
    end else if (byte_done_s) begin
      pending_n  = 1'b0;
    end else begin
      pending_n  = pending_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (cmd_start) begin
          index_n    = cmd_index;
          arg_n      = cmd_arg;
          crc_n      = cmd_crc;
          busy_n     = 1'b1;
          timeout_n  = 1'b0;
          cs_n_n     = 1'b0;
          fill_cnt_n = 4'd0;
          byte_cnt_n = 3'd0;
          poll_cnt_n = 8'd0;
          state_n    = (PRE_FILL > 0) ? ST_PRE : ST_SEND;
        end else begin
          state_n    = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (byte_done_s) begin
          if (fill_cnt_r == PRE_LAST) begin
            fill_cnt_n = 4'd0;
            state_n    = ST_SEND;
          end else begin
            fill_cnt_n = fill_cnt_r + 4'd1;
          end
        end else begin
          fill_cnt_n = fill_cnt_r;
        end
      end
      ST_SEND: begin
        if (byte_done_s) begin
          if (byte_cnt_r == 3'd5) begin
            poll_cnt_n = 8'd0;
            state_n    = ST_POLL;
          end else begin
            byte_cnt_n = byte_cnt_r + 3'd1;
          end
        end else begin
          byte_cnt_n = byte_cnt_r;
        end
      end
      ST_POLL: begin
        if (byte_done_s) begin
          if (!spi_in_word[7]) begin
            resp_n       = spi_in_word;
            timeout_n    = 1'b0;
            enter_post_s = 1'b1;
          end else if ((poll_cnt_r + 8'd1) == POLL_LIMIT) begin
            resp_n       = 8'hFF;
            timeout_n    = 1'b1;
            enter_post_s = 1'b1;
          end else begin
            poll_cnt_n   = poll_cnt_r + 8'd1;
          end
        end else begin
          poll_cnt_n = poll_cnt_r;
        end
      end
      ST_POST: begin
        if (byte_done_s) begin
          if (fill_cnt_r == POST_LAST) begin
            enter_done_s = 1'b1;
          end else begin
            fill_cnt_n   = fill_cnt_r + 4'd1;
          end
        end else begin
          fill_cnt_n = fill_cnt_r;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Releasing CS before the trailing fill gives the card its 8 idle clocks.
    if (enter_post_s) begin
      cs_n_n     = 1'b1;
      fill_cnt_n = 4'd0;
      if (POST_FILL > 0) begin
        state_n = ST_POST;
      end else begin
        enter_done_s = 1'b1;
      end
    end else begin
      cs_n_n = cs_n_n;
    end

    if (enter_done_s) begin
      state_n = ST_DONE;
      done_n  = 1'b1;
      busy_n  = 1'b0;
      cs_n_n  = 1'b1;
    end else begin
      done_n  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      byte_cnt_r <= 3'd0;
      fill_cnt_r <= 4'd0;
      poll_cnt_r <= 8'd0;
      pending_r  <= 1'b0;
      index_r    <= 6'd0;
      arg_r      <= 32'd0;
      crc_r      <= 7'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      resp_r     <= 8'hFF;
      timeout_r  <= 1'b0;
      cs_n_r     <= 1'b1;
      exec_r     <= 1'b0;
      out_word_r <= 8'hFF;
    end else begin
      state_r    <= state_n;
      byte_cnt_r <= byte_cnt_n;
      fill_cnt_r <= fill_cnt_n;
      poll_cnt_r <= poll_cnt_n;
      pending_r  <= pending_n;
      index_r    <= index_n;
      arg_r      <= arg_n;
      crc_r      <= crc_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      resp_r     <= resp_n;
      timeout_r  <= timeout_n;
      cs_n_r     <= cs_n_n;
      exec_r     <= exec_n;
      out_word_r <= out_word_n;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign resp_r1      = resp_r;
  assign timeout      = timeout_r;
  assign cs_n         = cs_n_r;
  assign spi_execute  = exec_r;
  assign spi_out_word = out_word_r;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a behavioural SPI byte controller
// and scripted card responses.
module tb_sd_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy;
  logic        done;
  logic [7:0]  resp_r1;
  logic        timeout;
  logic        cs_n;
  logic        spi_execute;
  logic [7:0]  spi_out_word;
  logic [7:0]  spi_in_word;
  logic        spi_finished;
  logic        spi_busy;

  int checks;
  int failures;

  logic [7:0] mosi_log [0:511];
  logic       cs_log   [0:511];
  logic [7:0] miso_tab [0:511];
  int         exec_idx;
  int         wide_cnt;
  int         busy_exec_cnt;
  int         done_cnt;

  logic [7:0] exp_bytes [0:15];
  int         base;
  int         done_base;
  bit         ok;

  sd_cmd_sequencer #(.RESP_TIMEOUT(8), .PRE_FILL(1), .POST_FILL(1)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .busy(busy), .done(done),
    .resp_r1(resp_r1), .timeout(timeout), .cs_n(cs_n), .spi_execute(spi_execute),
    .spi_out_word(spi_out_word), .spi_in_word(spi_in_word),
    .spi_finished(spi_finished), .spi_busy(spi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SPI controller: 5 busy cycles per byte, then a 1-cycle finish.
  initial begin
    int cur;
    int cnt;
    logic prev_exec;
    cur = 0; cnt = 0; prev_exec = 1'b0;
    exec_idx = 0; wide_cnt = 0; busy_exec_cnt = 0; done_cnt = 0;
    spi_busy = 1'b0; spi_finished = 1'b0; spi_in_word = 8'hFF;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (spi_finished) spi_finished = 1'b0;
      if (spi_execute && prev_exec) wide_cnt++;
      prev_exec = spi_execute;
      if (spi_execute) begin
        if (spi_busy) busy_exec_cnt++;
        cur = exec_idx;
        if (cur < 512) begin
          mosi_log[cur] = spi_out_word;
          cs_log[cur]   = cs_n;
        end
        exec_idx++;
        spi_busy = 1'b1;
        cnt = 5;
      end else if (spi_busy) begin
        cnt--;
        if (cnt == 0) begin
          spi_busy     = 1'b0;
          spi_finished = 1'b1;
          spi_in_word  = (cur < 512) ? miso_tab[cur] : 8'hFF;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [5:0] i, input logic [31:0] a, input logic [6:0] c);
    @(negedge clk);
    cmd_index = i; cmd_arg = a; cmd_crc = c; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_index = 6'h2A; cmd_arg = 32'hDEAD_BEEF; cmd_crc = 7'h11;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_bytes(input string tag, input int b, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_b%0d", tag, k), {24'd0, mosi_log[b + k]}, {24'd0, exp_bytes[k]});
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; cmd_crc = 7'd0;
    for (int k = 0; k < 512; k++) miso_tab[k] = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_resp", {24'd0, resp_r1}, 32'hFF);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_exec", {31'd0, spi_execute}, 32'd0);
    check("rst_word", {24'd0, spi_out_word}, 32'hFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CMD0, card answers 0x01 on the second poll (byte 8).
    #2 base = exec_idx; done_base = done_cnt;
    miso_tab[base + 8] = 8'h01;
    start_cmd(6'd0, 32'd0, 7'h4A);
    check("cmd0_busy", {31'd0, busy}, 32'd1);
    wait_done(ok);
    check("cmd0_done_seen", {31'd0, ok}, 32'd1);
    check("cmd0_resp", {24'd0, resp_r1}, 32'h01);
    check("cmd0_timeout", {31'd0, timeout}, 32'd0);
    check("cmd0_busy_at_done", {31'd0, busy}, 32'd0);
    check("cmd0_cs_at_done", {31'd0, cs_n}, 32'd1);
    @(negedge clk);
    check("cmd0_done_pulse", {31'd0, done}, 32'd0);
    check("cmd0_resp_hold", {24'd0, resp_r1}, 32'h01);
    #2;
    check("cmd0_execs", exec_idx - base, 32'd10);
    exp_bytes = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("cmd0", base, 10);

    // CMD8, R1 on first poll; chip select low PRE..POLL, high in POST.
    base = exec_idx;
    miso_tab[base + 7] = 8'h01;
    start_cmd(6'd8, 32'h0000_01AA, 7'h43);
    wait_done(ok);
    check("cmd8_done_seen", {31'd0, ok}, 32'd1);
    check("cmd8_resp", {24'd0, resp_r1}, 32'h01);
    #2;
    check("cmd8_execs", exec_idx - base, 32'd9);
    exp_bytes = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("cmd8", base, 9);
    for (int k = 0; k < 8; k++) check($sformatf("cmd8_cs%0d", k), {31'd0, cs_log[base + k]}, 32'd0);
    check("cmd8_cs_post", {31'd0, cs_log[base + 8]}, 32'd1);

    // CMD17 with a second cmd_start mid-SEND; R1=0x00 on poll 3 (byte 9).
    base = exec_idx; done_base = done_cnt;
    miso_tab[base + 9] = 8'h00;
    start_cmd(6'd17, 32'h1234_5678, 7'h2A);
    for (int k = 0; k < 400 && exec_idx < base + 3; k++) begin
      @(negedge clk); #2;
    end
    start_cmd(6'd24, 32'hCAFE_F00D, 7'h7F);
    wait_done(ok);
    check("cmd17_done_seen", {31'd0, ok}, 32'd1);
    check("cmd17_resp", {24'd0, resp_r1}, 32'h00);
    check("cmd17_timeout", {31'd0, timeout}, 32'd0);
    repeat (40) @(negedge clk);
    #2;
    check("cmd17_single_done", done_cnt - done_base, 32'd1);
    check("cmd17_execs", exec_idx - base, 32'd11);
    exp_bytes = '{8'hFF, 8'h51, 8'h12, 8'h34, 8'h56, 8'h78, 8'h55, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("cmd17", base, 11);

    // MISO held 0xFF: exactly 8 polls then timeout.
    base = exec_idx;
    start_cmd(6'd1, 32'd0, 7'h7C);
    wait_done(ok);
    check("to_done_seen", {31'd0, ok}, 32'd1);
    check("to_resp", {24'd0, resp_r1}, 32'hFF);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    #2;
    check("to_execs", exec_idx - base, 32'd16);
    check("to_cs_post", {31'd0, cs_log[base + 15]}, 32'd1);
    check("to_cs_last_poll", {31'd0, cs_log[base + 14]}, 32'd0);

    // R1 arriving on the final allowed poll (byte 14) is a real response.
    base = exec_idx;
    miso_tab[base + 14] = 8'h05;
    start_cmd(6'd1, 32'd0, 7'h7C);
    check("last_timeout_cleared", {31'd0, timeout}, 32'd0);
    wait_done(ok);
    check("last_done_seen", {31'd0, ok}, 32'd1);
    check("last_resp", {24'd0, resp_r1}, 32'h05);
    check("last_timeout", {31'd0, timeout}, 32'd0);
    #2;
    check("last_execs", exec_idx - base, 32'd16);

    // Reset while B3 is on the wire, then restart while the controller is still busy.
    base = exec_idx;
    start_cmd(6'd17, 32'h0A0B_0C0D, 7'h01);
    for (int k = 0; k < 400 && exec_idx < base + 5; k++) begin
      @(negedge clk); #2;
    end
    check("rst_mid_at_b3", {24'd0, mosi_log[base + 4]}, 32'h0C);
    reset = 1'b1;
    #1;
    check("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_spi_busy", {31'd0, spi_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #2 base = exec_idx;
    miso_tab[base + 7] = 8'h01;
    start_cmd(6'd55, 32'd0, 7'h32);
    wait_done(ok);
    check("rst_new_done_seen", {31'd0, ok}, 32'd1);
    check("rst_new_resp", {24'd0, resp_r1}, 32'h01);
    #2;
    check("rst_new_execs", exec_idx - base, 32'd9);
    exp_bytes = '{8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("rst_new", base, 9);

    check("exec_never_wide", wide_cnt, 32'd0);
    check("exec_never_busy", busy_exec_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
